// File: rtl/eth_pkg.sv
// Shared constants, header byte offsets and enums for the UDP receive parser.
// Checksum support is selected by UDP_RX_IP_CSUM_EN at build time.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    localparam logic [5:0] OFF_ETHERTYPE = 6'd12;
    localparam logic [5:0] OFF_IP_HDR    = 6'd14;
    localparam logic [5:0] OFF_IP_PROTO  = 6'd23;
    localparam logic [5:0] OFF_IP_DST    = 6'd30;
    localparam logic [5:0] OFF_UDP_HDR   = 6'd34;
    localparam logic [5:0] OFF_UDP_DPORT = 6'd36;
    localparam logic [5:0] OFF_UDP_LEN   = 6'd38;
    localparam logic [5:0] OFF_PAYLOAD   = 6'd42;

    typedef enum logic [2:0] {
        DR_NONE   = 3'd0,
        DR_MAC    = 3'd1,
        DR_ETYPE  = 3'd2,
        DR_IP_HDR = 3'd3,
        DR_IP_DST = 3'd4,
        DR_UDP    = 3'd5,
        DR_CSUM   = 3'd6,
        DR_TRUNC  = 3'd7
    } drop_reason_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_UDP_HDR,
        ST_PAYLOAD,
        ST_DROP,
        ST_DONE,
        ST_GAP
    } parser_state_t;

    // Byte i of a MAC address, most significant byte first; i 6/7 land in padding.
    function automatic logic [7:0] mac_byte(input logic [47:0] v, input logic [2:0] i);
        logic [63:0] w;
        w = {v, 16'h0000};
        return w[8*(7-int'(i)) +: 8];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] v, input logic [1:0] i);
        return v[8*(3-int'(i)) +: 8];
    endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Ones'-complement 16-bit accumulator over a byte stream, high byte first.
// Only compiled when UDP_RX_IP_CSUM_EN is defined.
`ifdef UDP_RX_IP_CSUM_EN
module ipv4_csum (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       clear,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       sum_ok
);
    logic [15:0] acc;
    logic [7:0]  hi;
    logic        lo_phase;
    logic [16:0] sum;

    assign sum    = {1'b0, acc} + {1'b0, hi, byte_in};
    assign sum_ok = (acc == 16'hFFFF);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc      <= 16'h0000;
            hi       <= 8'h00;
            lo_phase <= 1'b0;
        end else if (clear) begin
            acc      <= 16'h0000;
            lo_phase <= 1'b0;
        end else if (byte_valid) begin
            if (!lo_phase) hi <= byte_in;
            // End-around carry cannot overflow a second time.
            else acc <= sum[15:0] + {15'd0, sum[16]};
            lo_phase <= ~lo_phase;
        end
    end
endmodule
`endif

// File: rtl/udp_rx_parser.sv
// Ethernet/IPv4/UDP header filter that forwards only matching UDP payload bytes.
// Define UDP_RX_IP_CSUM_EN to also verify the IPv4 header checksum.
module udp_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0001,
    parameter logic [15:0] LOCAL_PORT = 16'h1388
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] data_out,
    output logic       udp_data_valid,
    output logic       pkt_ok,
    output logic       pkt_drop,
    output logic [2:0] drop_reason
);
    parser_state_t state, state_n;
    drop_reason_t  reason_q, reason_n, hdr_code;
    logic          rx_valid_d, sof, in_hdr, hdr_byte, hdr_fail;
    logic          emit, ok_n, drop_n;
    logic [5:0]    idx, bidx;
    logic          mac_loc_ok, mac_bc_ok, ip_ok;
    logic          hit_loc, hit_bc, hit_ip;
    logic [7:0]    fld_hi;
    logic [15:0]   udp_len, pay_cnt;

    assign sof      = rx_valid & ~rx_valid_d;
    assign in_hdr   = state inside {ST_ETH_HDR, ST_IP_HDR, ST_UDP_HDR};
    // Byte 0 arrives while still in IDLE, so the header index starts there.
    assign bidx     = (state == ST_IDLE) ? 6'd0 : idx;
    assign hdr_byte = ((state == ST_IDLE) && sof) || (in_hdr && rx_valid);
    assign hit_loc  = (rx_data == mac_byte(LOCAL_MAC, bidx[2:0]));
    assign hit_bc   = (rx_data == 8'hFF);
    assign hit_ip   = (rx_data == ip_byte(LOCAL_IP, 2'(bidx - OFF_IP_DST)));
    assign drop_reason = reason_q;

`ifdef UDP_RX_IP_CSUM_EN
    logic csum_clr, csum_vld, csum_ok;
    assign csum_clr = (state == ST_IDLE) && sof;
    assign csum_vld = hdr_byte && (bidx >= OFF_IP_HDR) && (bidx < OFF_UDP_HDR);
    ipv4_csum u_csum (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (csum_clr),
        .byte_in   (rx_data),
        .byte_valid(csum_vld),
        .sum_ok    (csum_ok)
    );
`endif

    // Field checks fire on the last byte of each field.
    always_comb begin
        hdr_fail = 1'b0;
        hdr_code = DR_NONE;
        case (bidx)
            6'd5:
                if (!((mac_loc_ok && hit_loc) || (mac_bc_ok && hit_bc))) begin
                    hdr_fail = 1'b1; hdr_code = DR_MAC;
                end
            OFF_ETHERTYPE + 6'd1:
                if ({fld_hi, rx_data} != ETHERTYPE_IPV4) begin
                    hdr_fail = 1'b1; hdr_code = DR_ETYPE;
                end
            OFF_IP_HDR:
                if (rx_data != IP_VER_IHL) begin
                    hdr_fail = 1'b1; hdr_code = DR_IP_HDR;
                end
            OFF_IP_PROTO:
                if (rx_data != IP_PROTO_UDP) begin
                    hdr_fail = 1'b1; hdr_code = DR_IP_HDR;
                end
            OFF_IP_DST + 6'd3:
                if (!(ip_ok && hit_ip)) begin
                    hdr_fail = 1'b1; hdr_code = DR_IP_DST;
                end
`ifdef UDP_RX_IP_CSUM_EN
            OFF_UDP_HDR:
                if (!csum_ok) begin
                    hdr_fail = 1'b1; hdr_code = DR_CSUM;
                end
`endif
            OFF_UDP_DPORT + 6'd1:
                if ({fld_hi, rx_data} != LOCAL_PORT) begin
                    hdr_fail = 1'b1; hdr_code = DR_UDP;
                end
            OFF_UDP_LEN + 6'd1:
                if ({fld_hi, rx_data} < 16'd8) begin
                    hdr_fail = 1'b1; hdr_code = DR_UDP;
                end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        reason_n = reason_q;
        drop_n   = 1'b0;
        ok_n     = 1'b0;
        emit     = 1'b0;
        case (state)
            ST_IDLE:
                if (sof) state_n = ST_ETH_HDR;
            ST_ETH_HDR, ST_IP_HDR, ST_UDP_HDR: begin
                if (!rx_valid) begin
                    state_n = ST_DROP; drop_n = 1'b1; reason_n = DR_TRUNC;
                end else if (hdr_fail) begin
                    state_n = ST_DROP; drop_n = 1'b1; reason_n = hdr_code;
                end else if (bidx == OFF_IP_HDR - 6'd1) begin
                    state_n = ST_IP_HDR;
                end else if (bidx == OFF_UDP_HDR - 6'd1) begin
                    state_n = ST_UDP_HDR;
                end else if (bidx == OFF_PAYLOAD - 6'd1) begin
                    if (udp_len == 16'd8) begin
                        state_n = ST_DONE; ok_n = 1'b1;
                    end else begin
                        state_n = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!rx_valid) begin
                    state_n = ST_DROP; drop_n = 1'b1; reason_n = DR_TRUNC;
                end else begin
                    emit = 1'b1;
                    if (pay_cnt + 16'd1 == udp_len - 16'd8) begin
                        state_n = ST_DONE; ok_n = 1'b1;
                    end
                end
            end
            ST_DROP, ST_DONE:
                if (!rx_valid) state_n = ST_GAP;
            ST_GAP:
                state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
    end

    // rx_valid_d resets high so a frame already running at reset release is skipped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            reason_q       <= DR_NONE;
            rx_valid_d     <= 1'b1;
            idx            <= 6'd0;
            mac_loc_ok     <= 1'b0;
            mac_bc_ok      <= 1'b0;
            ip_ok          <= 1'b0;
            fld_hi         <= 8'h00;
            udp_len        <= 16'd0;
            pay_cnt        <= 16'd0;
            data_out       <= 8'h00;
            udp_data_valid <= 1'b0;
            pkt_ok         <= 1'b0;
            pkt_drop       <= 1'b0;
        end else begin
            state          <= state_n;
            reason_q       <= reason_n;
            rx_valid_d     <= rx_valid;
            udp_data_valid <= emit;
            pkt_ok         <= ok_n;
            pkt_drop       <= drop_n;
            if (emit) begin
                data_out <= rx_data;
                pay_cnt  <= pay_cnt + 16'd1;
            end
            if (hdr_byte) begin
                idx        <= bidx + 6'd1;
                mac_loc_ok <= ((bidx == 6'd0) || mac_loc_ok) && hit_loc;
                mac_bc_ok  <= ((bidx == 6'd0) || mac_bc_ok) && hit_bc;
                ip_ok      <= ((bidx == OFF_IP_DST) || ip_ok) && hit_ip;
                if (bidx inside {OFF_ETHERTYPE, OFF_UDP_DPORT, OFF_UDP_LEN})
                    fld_hi <= rx_data;
                if (bidx == OFF_UDP_LEN + 6'd1)
                    udp_len <= {fld_hi, rx_data};
                if (bidx == OFF_PAYLOAD - 6'd1)
                    pay_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: doc/udp_rx_parser.md
# udp_rx_parser

Receive-side header parser that sits directly upstream of the 8-to-32 AXI-stream packer. It takes a contiguous per-frame Ethernet byte stream from the MAC (preamble/SFD already removed) and checks the Ethernet, IPv4 and UDP headers against local addresses. For matching frames it emits only the UDP payload bytes as `data_out`/`udp_data_valid`; all other frames are dropped silently, with a status pulse.

## Interface
- `LOCAL_MAC`, 48'h02_00_00_00_00_01: accepted destination MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- `LOCAL_IP`, 32'hC0A8_0001: accepted IPv4 destination address.
- `LOCAL_PORT`, 16'h1388: accepted UDP destination port.
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: frame byte, starting at the first destination-MAC byte.
- `rx_valid` in 1: high for every byte of a frame with no gaps; low between frames.
- `data_out` out 8: UDP payload byte.
- `udp_data_valid` out 1: payload byte valid; contiguous for one payload.
- `pkt_ok` out 1: one-cycle pulse when a payload completes with its full UDP length.
- `pkt_drop` out 1: one-cycle pulse when a frame is rejected or truncated.
- `drop_reason` out 3: reason code, valid on `pkt_drop`; holds its last value otherwise.

## Operation
- There is no backpressure. Downstream must accept one byte per cycle.
- Start of frame: `rx_valid` is high and its registered copy `rx_valid_d` is low. `rx_valid_d` resets to 1, so a frame already in progress when reset releases is ignored until `rx_valid` next goes low.
- States:
  - IDLE → ETH_HDR at start of frame.
  - ETH_HDR covers bytes 0-13; → IP_HDR.
  - IP_HDR covers bytes 14-33; → UDP_HDR.
  - UDP_HDR covers bytes 34-41; → PAYLOAD, or → DONE if UDP length = 8.
  - PAYLOAD; → DONE when the payload counter reaches length−8.
  - DROP waits for `rx_valid` low; → GAP.
  - DONE waits for `rx_valid` low; → GAP.
  - GAP lasts one cycle; → IDLE.
- Byte index counter: 6 bits, used in the header states. Payload counter: 16 bits.
- Checks are made as each field completes. The first failing check jumps to DROP and pulses `pkt_drop` with a reason code:
  - 1: destination MAC mismatch (bytes 0-5).
  - 2: ethertype ≠ 0x0800 (bytes 12-13).
  - 3: byte 14 ≠ 0x45 (IPv4 with no options only), or protocol byte 23 ≠ 0x11.
  - 4: destination IP mismatch (bytes 30-33).
  - 5: destination port mismatch (bytes 36-37), or UDP length (bytes 38-39) < 8.
  - 6: header checksum failure (see Configuration).
  - 7: truncation. `rx_valid` fell before the payload completed, in any header state or in PAYLOAD.
- Truncation in PAYLOAD: `udp_data_valid` drops on the next cycle. The bytes already emitted stand; there is no retraction.
- Trailing Ethernet pad and FCS after the UDP length are consumed in DONE and never emitted.
- Zero-length payload (UDP length = 8): `pkt_ok` pulses, and `udp_data_valid` is never asserted.

## Timing
- Reset values: `data_out` = 0, `udp_data_valid` = 0, `pkt_ok` = 0, `pkt_drop` = 0, `drop_reason` = 0, state = IDLE.
- Latency: the input byte at cycle t appears on `data_out` at cycle t+1. All outputs are registered.
- First payload byte: input byte 42. `udp_data_valid` first rises one cycle after that byte is presented.
- `pkt_ok` pulses in the same cycle as the last `udp_data_valid` byte.
- `pkt_drop` pulses one cycle after the offending byte, or one cycle after `rx_valid` falls for truncation.
- Gap between payloads: `udp_data_valid` is low for ≥2 cycles between payloads. This is guaranteed by the DONE/DROP → GAP path; the downstream packer requires it.
- Asynchronous reset mid-payload: `udp_data_valid` clears immediately, with no pulse.

## Configuration
- `UDP_RX_IP_CSUM_EN` defined:
  - IPv4 header bytes 14-33 are summed as ten 16-bit words with a ones'-complement sum.
  - If the folded result ≠ 0xFFFF, the frame goes to DROP with reason 6, decided one cycle after byte 33 (before any payload).
- Undefined: no checksum logic is built, and reason 6 never occurs.

## Structure
- Package `eth_pkg` holds:
  - the constants `ETHERTYPE_IPV4` = 16'h0800, `IP_PROTO_UDP` = 8'h11, `IP_VER_IHL` = 8'h45;
  - the header offsets 12, 14, 23, 30, 36, 38, 42;
  - the `drop_reason_t` enum and the parser state enum.
- One sub-module, `ipv4_csum`: a 16-bit ones'-complement accumulator. Ports: clear, byte + valid, `sum_ok`. It is instantiated only under `UDP_RX_IP_CSUM_EN`.

## Test plan
- Broadcast MAC, IP 192.168.0.1, port 0x1388, UDP length 12, payload DE AD BE EF → 4 contiguous `udp_data_valid` cycles, bytes in order, `pkt_ok` on EF, FCS not emitted.
- Same frame with ethertype 0x86DD → `pkt_drop`, `drop_reason` = 2, no `udp_data_valid`.
- Destination port 0x1389 → `drop_reason` = 5; a following valid frame after a 12-cycle gap passes normally.
- UDP length 100, `rx_valid` falls after 10 payload bytes → 10 bytes emitted, `pkt_drop`, `drop_reason` = 7, no `pkt_ok`.
- `aresetn` released mid-frame → no output for that frame; the next frame parses correctly.
- With `UDP_RX_IP_CSUM_EN`: corrupt checksum bytes 24-25 → `drop_reason` = 6, no payload; a correct checksum passes.
